// File: rtl/uart_sdram_loader_pkg.sv
// Shared types and widths for the UART-to-SDRAM loader: SDRAM request widths,
// FSM encodings and a counter-width helper.
package uart_sdram_loader_pkg;

  localparam int SDRAM_AW = 22;
  localparam int SDRAM_DW = 16;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} wr_state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling on a down-counting bit timer.
//  state    | meaning
//  RX_IDLE  | line idle, waiting for synchronized rx low
//  RX_START | half-bit wait, then confirm start bit (high = glitch)
//  RX_DATA  | sample 8 data bits LSB first, one per DIV cycles
//  RX_STOP  | sample stop bit: 1 = byte_valid, 0 = ferr_pulse
module uart_rx_byte
  import uart_sdram_loader_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       ferr_pulse,
  output logic       start_pulse
);

  localparam int TW = cnt_width(DIV);

  logic          rx_s1, rx_s2;
  rx_state_t     state, state_nxt;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tick;

  assign tick    = (timer == '0);
  assign rx_byte = shreg;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (!rx_s2) state_nxt = RX_START;
      RX_START: if (tick) state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_cnt == 3'd7) state_nxt = RX_STOP;
      RX_STOP:  if (tick) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    start_pulse = (state == RX_IDLE) && !rx_s2;
    byte_valid  = (state == RX_STOP) && tick && rx_s2;
    ferr_pulse  = (state == RX_STOP) && tick && !rx_s2;
  end

  // The timer is preloaded with a half bit in idle so the first tick lands mid start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (state == RX_IDLE) begin
      timer   <= TW'(DIV / 2 - 1);
      bit_cnt <= '0;
    end else if (tick) begin
      timer <= TW'(DIV - 1);
      if (state == RX_DATA) begin
        shreg   <= {rx_s2, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end else begin
      timer <= timer - TW'(1);
    end
  end

endmodule

// File: rtl/uart_sdram_loader.sv
// Packs UART bytes little-endian into 16-bit words and writes them to consecutive
// SDRAM word addresses; an idle timeout re-arms the stream at BASE_ADDR.
//  state  | meaning
//  W_IDLE | no write outstanding, accepts the next word
//  W_REQ  | wren held with latched address/data until controller raises busy
//  W_WAIT | controller busy with our write
module uart_sdram_loader
  import uart_sdram_loader_pkg::*;
#(
  parameter int                  CLK_HZ    = 100_000_000,
  parameter int                  BAUD      = 115200,
  parameter logic [SDRAM_AW-1:0] BASE_ADDR = '0,
  parameter int                  TIMEOUT   = 1_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rx,
  input  logic                busy,
  output logic                wren,
  output logic                rden,
  output logic [SDRAM_AW-1:0] address,
  output logic [SDRAM_DW-1:0] data_wr,
  output logic                active,
  output logic                overrun,
  output logic                ferr
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int TOW = cnt_width(TIMEOUT);

  logic [7:0]          rx_byte;
  logic                byte_valid, ferr_pulse, start_pulse;
  logic                phase_hi, word_ready, timeout, accept;
  logic [7:0]          lo_byte;
  logic [SDRAM_DW-1:0] word;
  logic [SDRAM_AW-1:0] ptr;
  logic [TOW-1:0]      to_cnt;
  wr_state_t           state, state_nxt;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .ferr_pulse (ferr_pulse),
    .start_pulse(start_pulse)
  );

  // A completed byte (good or bad) in the timeout cycle suppresses the timeout.
  assign timeout = active && (to_cnt == '0) && !byte_valid && !ferr_pulse;

  always_ff @(posedge clock) begin
    if (reset) begin
      active <= 1'b0;
      to_cnt <= TOW'(TIMEOUT);
    end else begin
      if (start_pulse)  active <= 1'b1;
      else if (timeout) active <= 1'b0;
      if (!active || byte_valid || ferr_pulse) to_cnt <= TOW'(TIMEOUT);
      else if (to_cnt != '0)                   to_cnt <= to_cnt - TOW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_hi   <= 1'b0;
      lo_byte    <= '0;
      word       <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (byte_valid) begin
        phase_hi <= !phase_hi;
        if (!phase_hi) begin
          lo_byte <= rx_byte;
        end else begin
          word       <= {rx_byte, lo_byte};
          word_ready <= 1'b1;
        end
      end else if (timeout) begin
        phase_hi <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= W_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      W_IDLE:  if (word_ready) state_nxt = W_REQ;
      W_REQ:   if (busy) state_nxt = W_WAIT;
      W_WAIT:  if (!busy) state_nxt = W_IDLE;
      default: state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    wren   = (state == W_REQ);
    rden   = 1'b0;
    accept = (state == W_IDLE) && word_ready;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      address <= BASE_ADDR;
      data_wr <= '0;
      ptr     <= BASE_ADDR;
      overrun <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      if (accept) begin
        address <= ptr;
        data_wr <= word;
      end
      if (timeout)     ptr <= BASE_ADDR;
      else if (accept) ptr <= ptr + SDRAM_AW'(1);
      if (word_ready && state != W_IDLE) overrun <= 1'b1;
      if (ferr_pulse) ferr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_sdram_loader.sv
// Scoreboard bench: two loaders (base 0 and base 3FFFFF) share one rx line; each
// has its own 3-cycle busy responder that pops and checks accepted writes.
module tb_uart_sdram_loader;

  localparam int BIT     = 10;
  localparam int TIMEOUT = 500;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx    = 1'b1;
  logic        busy    [2];
  logic        wren    [2];
  logic        rden    [2];
  logic [21:0] address [2];
  logic [15:0] data_wr [2];
  logic        active  [2];
  logic        overrun [2];
  logic        ferr    [2];

  int          checks = 0;
  int          errors = 0;
  logic [37:0] exp0[$];
  logic [37:0] exp1[$];
  logic [21:0] base_m [2] = '{22'h000000, 22'h3FFFFF};
  logic [21:0] ptr_m  [2];
  bit          phase_hi;
  logic [7:0]  lo_m;
  bit          hold = 0;
  bit          no_accept = 0;

  always #5 clock = ~clock;

  uart_sdram_loader #(.CLK_HZ(1_000_000), .BAUD(100_000), .BASE_ADDR(22'h000000), .TIMEOUT(TIMEOUT)) u_a (
    .clock(clock), .reset(reset), .rx(rx), .busy(busy[0]), .wren(wren[0]), .rden(rden[0]),
    .address(address[0]), .data_wr(data_wr[0]), .active(active[0]), .overrun(overrun[0]), .ferr(ferr[0]));

  uart_sdram_loader #(.CLK_HZ(1_000_000), .BAUD(100_000), .BASE_ADDR(22'h3FFFFF), .TIMEOUT(TIMEOUT)) u_b (
    .clock(clock), .reset(reset), .rx(rx), .busy(busy[1]), .wren(wren[1]), .rden(rden[1]),
    .address(address[1]), .data_wr(data_wr[1]), .active(active[1]), .overrun(overrun[1]), .ferr(ferr[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes pair little-endian into words at consecutive addresses.
  task automatic model_byte(input logic [7:0] b, input bit drop);
    if (!phase_hi) begin
      lo_m     = b;
      phase_hi = 1;
    end else begin
      phase_hi = 0;
      if (!drop) begin
        exp0.push_back({ptr_m[0], b, lo_m});
        exp1.push_back({ptr_m[1], b, lo_m});
        ptr_m[0] = ptr_m[0] + 22'd1;
        ptr_m[1] = ptr_m[1] + 22'd1;
      end
    end
  endtask

  task automatic model_rearm();
    phase_hi = 0;
    ptr_m[0] = base_m[0];
    ptr_m[1] = base_m[1];
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clock);
    rx = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clock);
    end
    if (stop_ok) begin
      rx = 1'b1;
      repeat (BIT) @(negedge clock);
    end else begin
      rx = 1'b0;
      repeat (7) @(negedge clock);
      rx = 1'b1;
      repeat (BIT) @(negedge clock);
    end
  endtask

  task automatic send_good(input logic [7:0] b, input bit drop);
    model_byte(b, drop);
    send_byte(b, 1'b1);
    repeat ($urandom_range(20, 0)) @(negedge clock);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || busy[0] || busy[1]) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d/%0d required=0", exp0.size(), exp1.size());
    end
  endtask

  task automatic idle_rearm();
    repeat (TIMEOUT + 100) @(negedge clock);
    check("active_after_timeout", active[0], 0);
    model_rearm();
  endtask

  // Busy responder and write monitor for each loader.
  logic [37:0] acc_v [2];
  int          left  [2] = '{0, 0};
  bit          pend  [2] = '{0, 0};
  initial begin
    logic [37:0] e;
    busy[0] = 1'b0;
    busy[1] = 1'b0;
    forever begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        if (pend[k]) begin
          check("wren_hold", wren[k], 1);
          check("req_stable", {address[k], data_wr[k]}, acc_v[k]);
          busy[k] = 1'b1;
          left[k] = 2;
          pend[k] = 0;
        end else if (busy[k]) begin
          if (!hold) begin
            if (left[k] == 2) check("wren_drop", wren[k], 0);
            left[k]--;
            if (left[k] == 0) busy[k] = 1'b0;
          end
        end else if (wren[k] && !no_accept) begin
          acc_v[k] = {address[k], data_wr[k]};
          pend[k]  = 1;
          if ((k == 0 ? exp0.size() : exp1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write dut=%0d actual=%0h required=none", k, acc_v[k]);
          end else begin
            e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
            check(k == 0 ? "write_a" : "write_b", acc_v[k], e);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    model_rearm();
    repeat (5) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      check("rst_wren", wren[k], 0);
      check("rst_rden", rden[k], 0);
      check("rst_address", address[k], base_m[k]);
      check("rst_data", data_wr[k], 0);
      check("rst_flags", {active[k], overrun[k], ferr[k]}, 0);
    end
    reset = 1'b0;

    send_good(8'h34, 0);
    send_good(8'h12, 0);
    drain();
    check("active_stream", active[0], 1);
    idle_rearm();

    for (int i = 1; i <= 6; i++) send_good(8'(i), 0);
    for (int i = 0; i < 2; i++) send_good(8'($urandom_range(255, 0)), 0);
    drain();
    check("overrun_clear", overrun[0], 0);
    idle_rearm();

    for (int i = 0; i < 10; i++) send_good(8'($urandom_range(255, 0)), 0);
    drain();
    idle_rearm();

    @(negedge clock);
    rx = 1'b0;
    repeat (3) @(negedge clock);
    rx = 1'b1;
    repeat (50) @(negedge clock);
    check("glitch_no_ferr", ferr[0], 0);
    send_byte(8'h5A, 1'b0);
    repeat (5) @(negedge clock);
    check("ferr_set", ferr[0], 1);
    check("ferr_set_b", ferr[1], 1);
    send_good(8'hC3, 0);
    send_good(8'h3C, 0);
    drain();
    idle_rearm();

    send_good(8'hAA, 0);
    idle_rearm();
    send_good(8'h11, 0);
    check("active_rearmed", active[0], 1);
    send_good(8'h22, 0);
    drain();
    idle_rearm();

    hold = 1;
    send_good(8'h01, 0);
    send_good(8'h02, 0);
    for (int i = 0; i < 4; i++) send_good(8'($urandom_range(255, 0)), 1);
    repeat (5) @(negedge clock);
    check("overrun_a", overrun[0], 1);
    check("overrun_b", overrun[1], 1);
    hold = 0;
    drain();
    send_good(8'h77, 0);
    send_good(8'h88, 0);
    drain();

    no_accept = 1;
    b = 8'($urandom_range(255, 0));
    send_good(b, 1);
    send_good(~b, 1);
    begin
      int n = 0;
      while (!wren[0] && n < 300) begin
        @(negedge clock);
        n++;
      end
      check("wren_stalled", wren[0], 1);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_drops_wren_a", wren[0], 0);
    check("rst_drops_wren_b", wren[1], 0);
    @(negedge clock);
    reset = 1'b0;
    no_accept = 0;
    model_rearm();
    check("rst_clears_sticky", {overrun[0], ferr[0], active[0]}, 0);
    send_good(8'hEF, 0);
    send_good(8'hBE, 0);
    drain();
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL queue_empty actual=%0d/%0d required=0", exp0.size(), exp1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
